reg_bank_writer: RTL and testbench
==================================

REG_BANK_WRITER -- requirements
Module: reg_bank_writer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data width of each register.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the number of write-queue entries (power of two, ≥2).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock, with all state updating on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port wr_valid, input, 1 bit, which is high when a write request is offered.
REQ-006 The block SHALL have port wr_ready, output, 1 bit, which is high when the block can accept a write request.
REQ-007 The block SHALL have port wr_sel, input, 4 bits, the target register index.
REQ-008 The block SHALL have port wr_data, input, WIDTH bits, the write value.
REQ-009 The block SHALL have port hold, input, 1 bit, which stalls commits to the bank while high.
REQ-010 The block SHALL have port rd_sel, input, 4 bits, the read-port register index.
REQ-011 The block SHALL have port rd_data, output, WIDTH bits, the read-port value.
REQ-012 The block SHALL have ports r0 to r7, output, WIDTH bits each, carrying the committed register contents.
REQ-013 The block SHALL have port pend_count, output, clog2(DEPTH)+1 bits, the number of queued writes.
REQ-014 The block SHALL have port sel_err, output, 1 bit, a one-cycle pulse raised when a write is dropped for an invalid index.

Function
REQ-015 The block SHALL accept a request on a rising edge when wr_valid and wr_ready are both high, pushing {wr_sel, wr_data} into an in-order FIFO.
REQ-016 wr_ready SHALL equal (pend_count < DEPTH), be registered-state-derived only, and not depend combinationally on wr_valid or hold.
REQ-017 When hold is low and the queue is non-empty, the block SHALL pop the head entry and commit it on each rising edge, at most one commit per cycle.
REQ-018 A commit with wr_sel[3]=0 SHALL write wr_data to r[wr_sel[2:0]]; that value SHALL be visible on the r output after the commit edge.
REQ-019 A commit with wr_sel[3]=1 SHALL leave the bank unchanged and SHALL assert sel_err for exactly the following cycle.
REQ-020 The latency from acceptance at edge N to commit SHALL be edge N+1 when the queue was empty and hold is low; writes SHALL commit in acceptance order.
REQ-021 A push and a pop in the same cycle SHALL leave pend_count unchanged.
REQ-022 Pointers SHALL wrap modulo DEPTH.
REQ-023 While hold is high, no commit SHALL occur; the block SHALL keep accepting requests until the queue is full.
REQ-024 rd_data SHALL be a combinational function of rd_sel and the state: r[rd_sel[2:0]] when rd_sel[3]=0, and 0 when rd_sel[3]=1.

Reset
REQ-025 While rst_n is low, r0 to r7 SHALL be 0, the queue SHALL be empty, pend_count SHALL be 0, wr_ready SHALL be 1, and sel_err SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL immediately discard all queued writes; none SHALL commit after reset release.
REQ-027 The first acceptance SHALL be possible on the first rising edge at which rst_n is high.

Configuration
REQ-028 With macro REG_BANK_WRITER_FWD_EN defined, rd_data SHALL return the data of the youngest queued valid entry whose wr_sel equals rd_sel, falling back to the committed value when there is no match.
REQ-029 With REG_BANK_WRITER_FWD_EN undefined, rd_data SHALL show committed bank contents only; r0 to r7 SHALL show committed contents in both builds.

Verification
REQ-030 Reset, then write sel=3 data=0xBEEF with hold=0 -> r3=0xBEEF one edge after acceptance, and all other registers remain 0.
REQ-031 hold=1, then accept sel=1/0x1111 and sel=1/0x2222 -> wr_ready=0 and pend_count=2; on hold=0, r1=0x1111 then 0x2222 on consecutive edges.
REQ-032 Write sel=8 data=0xFFFF -> bank unchanged and sel_err high for exactly one cycle.
REQ-033 hold=1 with sel=5/0xAAAA queued, and rd_sel=5 -> rd_data=0xAAAA with FWD_EN defined and 0x0000 without it; rd_sel=9 -> rd_data=0.
REQ-034 With queue full and hold=1, pulse rst_n low -> after release pend_count=0, wr_ready=1, r0 to r7 are 0, and nothing commits after hold=0.
REQ-035 With hold=0, offer a write every cycle for 10 cycles -> wr_ready stays 1, pend_count ≤1, and all 10 writes land in order.

Source files
------------

// File: rtl/reg_bank_writer.sv
// Eight-entry register bank fed through an in-order write queue, with hold stall and bad-index flag.
// Define REG_BANK_WRITER_FWD_EN to let rd_data forward the youngest matching queued write.
module reg_bank_writer #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [3:0]               wr_sel,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     hold,
   input  logic [3:0]               rd_sel,
   output logic [WIDTH-1:0]         rd_data,
   output logic [WIDTH-1:0]         r0,
   output logic [WIDTH-1:0]         r1,
   output logic [WIDTH-1:0]         r2,
   output logic [WIDTH-1:0]         r3,
   output logic [WIDTH-1:0]         r4,
   output logic [WIDTH-1:0]         r5,
   output logic [WIDTH-1:0]         r6,
   output logic [WIDTH-1:0]         r7,
   output logic [$clog2(DEPTH):0]   pend_count,
   output logic                     sel_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DepthC = CW'(DEPTH);

   logic [WIDTH-1:0] r_bank   [8];
   logic [3:0]       r_q_sel  [DEPTH];
   logic [WIDTH-1:0] r_q_data [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_sel_err;

   logic             w_push;
   logic             w_pop;
   logic [3:0]       w_head_sel;
   logic [WIDTH-1:0] w_head_data;
   logic [WIDTH-1:0] w_rd_data;

   assign wr_ready    = (r_count < DepthC);
   assign w_push      = wr_valid && wr_ready;
   assign w_pop       = !hold && (r_count != '0);
   assign w_head_sel  = r_q_sel[r_rd_ptr];
   assign w_head_data = r_q_data[r_rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_sel_err <= 1'b0;
         for (int i = 0; i < 8; i++) r_bank[i] <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         r_sel_err <= w_pop && w_head_sel[3];
         if (w_pop && !w_head_sel[3]) r_bank[w_head_sel[2:0]] <= w_head_data;
      end
   end

   // Queue payload needs no reset: entries are only read when counted as valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_sel[r_wr_ptr]  <= wr_sel;
         r_q_data[r_wr_ptr] <= wr_data;
      end
   end

`ifdef REG_BANK_WRITER_FWD_EN
   logic [AW-1:0] w_fwd_idx;

   // Walk oldest to youngest so the last match (youngest) wins.
   always_comb begin
      w_rd_data = '0;
      w_fwd_idx = '0;
      if (!rd_sel[3]) begin
         w_rd_data = r_bank[rd_sel[2:0]];
         for (int i = 0; i < DEPTH; i++) begin
            w_fwd_idx = r_rd_ptr + AW'(i);
            if ((CW'(i) < r_count) && (r_q_sel[w_fwd_idx] == rd_sel)) begin
               w_rd_data = r_q_data[w_fwd_idx];
            end
         end
      end
   end
`else
   always_comb begin
      w_rd_data = '0;
      if (!rd_sel[3]) w_rd_data = r_bank[rd_sel[2:0]];
   end
`endif

   assign rd_data    = w_rd_data;
   assign pend_count = r_count;
   assign sel_err    = r_sel_err;
   assign r0         = r_bank[0];
   assign r1         = r_bank[1];
   assign r2         = r_bank[2];
   assign r3         = r_bank[3];
   assign r4         = r_bank[4];
   assign r5         = r_bank[5];
   assign r6         = r_bank[6];
   assign r7         = r_bank[7];

endmodule

// File: tb/tb_reg_bank_writer.sv
// Self-checking bench for reg_bank_writer: queue/bank model compared every cycle plus directed literals.
// Honours REG_BANK_WRITER_FWD_EN the same way as the design.
module tb_reg_bank_writer;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned DEPTH = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             wr_valid;
   logic             wr_ready;
   logic [3:0]       wr_sel;
   logic [WIDTH-1:0] wr_data;
   logic             hold;
   logic [3:0]       rd_sel;
   logic [WIDTH-1:0] rd_data;
   logic [WIDTH-1:0] r0, r1, r2, r3, r4, r5, r6, r7;
   logic [1:0]       pend_count;
   logic             sel_err;

   int n_checks = 0;
   int n_pass   = 0;

   reg_bank_writer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_sel     (wr_sel),
      .wr_data    (wr_data),
      .hold       (hold),
      .rd_sel     (rd_sel),
      .rd_data    (rd_data),
      .r0         (r0),
      .r1         (r1),
      .r2         (r2),
      .r3         (r3),
      .r4         (r4),
      .r5         (r5),
      .r6         (r6),
      .r7         (r7),
      .pend_count (pend_count),
      .sel_err    (sel_err)
   );

   always #5 clk = ~clk;

   // Behavioural model: a queue of pending writes and an array for the bank.
   typedef struct {
      logic [3:0]       sel;
      logic [WIDTH-1:0] data;
   } ent_t;

   ent_t             m_q[$];
   ent_t             m_e;
   logic [WIDTH-1:0] m_bank[8] = '{default: '0};
   logic             m_err = 1'b0;
   bit               m_acc;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         for (int i = 0; i < 8; i++) m_bank[i] = '0;
         m_err = 1'b0;
      end else begin
         m_acc = wr_valid && (m_q.size() < DEPTH);
         m_err = 1'b0;
         if (!hold && m_q.size() > 0) begin
            m_e = m_q.pop_front();
            if (m_e.sel[3]) m_err = 1'b1;
            else m_bank[m_e.sel[2:0]] = m_e.data;
         end
         if (m_acc) m_q.push_back('{sel: wr_sel, data: wr_data});
      end
   end

   function automatic logic [WIDTH-1:0] m_rd(input logic [3:0] sel);
      logic [WIDTH-1:0] v;
      v = '0;
      if (!sel[3]) begin
         v = m_bank[sel[2:0]];
`ifdef REG_BANK_WRITER_FWD_EN
         foreach (m_q[i]) if (m_q[i].sel == sel) v = m_q[i].data;
`endif
      end
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      else n_pass++;
   endtask

   logic [WIDTH-1:0] dut_r[8];
   assign dut_r = '{r0, r1, r2, r3, r4, r5, r6, r7};

   always @(negedge clk) begin
      for (int i = 0; i < 8; i++) chk($sformatf("model_r%0d", i), 32'(dut_r[i]), 32'(m_bank[i]));
      chk("model_pend", 32'(pend_count), 32'(m_q.size()));
      chk("model_ready", 32'(wr_ready), 32'(m_q.size() < DEPTH));
      chk("model_sel_err", 32'(sel_err), 32'(m_err));
      chk("model_rd_data", 32'(rd_data), 32'(m_rd(rd_sel)));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [3:0] sel, input logic [WIDTH-1:0] data);
      wr_valid = 1'b1;
      wr_sel   = sel;
      wr_data  = data;
   endtask

`ifdef REG_BANK_WRITER_FWD_EN
   localparam bit FwdOn = 1'b1;
`else
   localparam bit FwdOn = 1'b0;
`endif

   initial begin
      wr_valid = 1'b0;
      wr_sel   = '0;
      wr_data  = '0;
      hold     = 1'b0;
      rd_sel   = '0;
      rst_n    = 1'b1;
      #1 rst_n = 1'b0;
      step();
      step();
      chk("rst_ready", 32'(wr_ready), 32'd1);
      chk("rst_pend", 32'(pend_count), 32'd0);
      chk("rst_r3", 32'(r3), 32'd0);

      // Release and offer on the very first edge with rst_n high.
      rst_n = 1'b1;
      offer(4'd3, 16'hBEEF);
      step();
      chk("first_accept_pend", 32'(pend_count), 32'd1);
      wr_valid = 1'b0;
      step();
      chk("beef_r3", 32'(r3), 32'h0000_BEEF);
      chk("beef_r0", 32'(r0), 32'd0);
      chk("beef_pend", 32'(pend_count), 32'd0);

      hold = 1'b1;
      offer(4'd1, 16'h1111);
      step();
      offer(4'd1, 16'h2222);
      step();
      wr_valid = 1'b0;
      chk("hold_ready", 32'(wr_ready), 32'd0);
      chk("hold_pend", 32'(pend_count), 32'd2);
      chk("hold_r1", 32'(r1), 32'd0);
      hold = 1'b0;
      step();
      chk("order_r1_a", 32'(r1), 32'h0000_1111);
      step();
      chk("order_r1_b", 32'(r1), 32'h0000_2222);

      offer(4'd8, 16'hFFFF);
      step();
      wr_valid = 1'b0;
      step();
      chk("bad_sel_err_hi", 32'(sel_err), 32'd1);
      chk("bad_sel_r0", 32'(r0), 32'd0);
      step();
      chk("bad_sel_err_lo", 32'(sel_err), 32'd0);

      hold = 1'b1;
      offer(4'd5, 16'hAAAA);
      step();
      wr_valid = 1'b0;
      rd_sel   = 4'd5;
      #1;
      chk("fwd_rd5", 32'(rd_data), FwdOn ? 32'h0000_AAAA : 32'd0);
      rd_sel = 4'd9;
      #1;
      chk("rd_sel9", 32'(rd_data), 32'd0);
      offer(4'd5, 16'hBBBB);
      step();
      wr_valid = 1'b0;
      rd_sel   = 4'd5;
      #1;
      chk("fwd_youngest", 32'(rd_data), FwdOn ? 32'h0000_BBBB : 32'd0);
      chk("full_pend", 32'(pend_count), 32'd2);

      // Mid-operation reset with a full queue under hold.
      rst_n = 1'b0;
      #2;
      chk("midrst_pend", 32'(pend_count), 32'd0);
      chk("midrst_ready", 32'(wr_ready), 32'd1);
      chk("midrst_r3", 32'(r3), 32'd0);
      chk("midrst_r1", 32'(r1), 32'd0);
      rst_n = 1'b1;
      hold  = 1'b0;
      step();
      step();
      step();
      chk("midrst_no_commit_r5", 32'(r5), 32'd0);
      chk("midrst_no_commit_pend", 32'(pend_count), 32'd0);

      for (int i = 0; i < 10; i++) begin
         offer(4'(i % 8), 16'hA000 + 16'(i));
         rd_sel = 4'(i % 8);
         step();
         chk($sformatf("stream_pend_le1_%0d", i), 32'(pend_count <= 2'd1), 32'd1);
         chk($sformatf("stream_ready_%0d", i), 32'(wr_ready), 32'd1);
      end
      wr_valid = 1'b0;
      step();
      chk("stream_r0", 32'(r0), 32'h0000_A008);
      chk("stream_r1", 32'(r1), 32'h0000_A009);
      chk("stream_r2", 32'(r2), 32'h0000_A002);
      chk("stream_r7", 32'(r7), 32'h0000_A007);
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
